sha_result_tx: RTL
==================

# sha_result_tx

Transmit side of the miner's host link: watches the solution outputs of `sha_hasher` (valid flag, time, nonce, final hash). It captures each newly found solution, serialises it into a framed byte stream with a checksum, and drives it out over a valid/ready byte interface toward the UART/USB bridge. The block sits between `sha_hasher` and the host transport and is the counterpart of the work-loading path that feeds the hasher.

## Interface
Parameters:
- `SYNC_BYTE`, 8'hA5: first byte of every frame.
- `SEND_RESULT`, 1: 1 = append the 256-bit hash to the frame (long frame); 0 = time+nonce only (short frame).

Ports:
- `CLK`  in  1  clock.
- `RST`  in  1  reset, asynchronous, active-low.
- `sol_valid`  in  1  solution flag from hasher; level, held high while the solution is pending.
- `sol_time`  in  32  time of solution.
- `sol_nonce`  in  32  nonce of solution.
- `sol_result`  in  256  final hash.
- `tx_data`  out  8  byte being offered.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  sink accepts the byte this cycle.
- `busy`  out  1  frame capture/transmission in progress.
- `overrun`  out  1  sticky: a new solution edge arrived while busy.
- `frame_count`  out  16  frames fully sent, wraps at 16'hFFFF→0.

## Operation
- Edge detect:
  - `sol_prev` is a register of `sol_valid`, reset to 0.
  - Trigger = `sol_valid & ~sol_prev`.
  - A `sol_valid` held high out of reset counts as one trigger.
- Capture:
  - On a trigger while in IDLE, latch `sol_time`, `sol_nonce` and `sol_result` into a shadow register.
  - The frame always uses the snapshot; later input changes do not affect it.
- Trigger while not IDLE: the trigger is ignored and `overrun` is set to 1. It stays set until reset.
- Frame byte order:
  1. `SYNC_BYTE`
  2. TYPE: 8'h01 short, 8'h02 long
  3. time, 4 bytes, MSB first
  4. nonce, 4 bytes, MSB first
  5. if `SEND_RESULT`: hash, 32 bytes, `sol_result[255:248]` first
  6. CSUM
- CSUM = (0 − Σ bytes from TYPE through last payload byte) mod 256. The sum of TYPE..CSUM is therefore ≡ 0 mod 256. `SYNC_BYTE` is excluded from the sum.
- Frame length: 11 bytes short, 43 bytes long.
- FSM states:
  - IDLE: on trigger → SYNC.
  - SYNC: on accept → TYPE.
  - TYPE: on accept → PAYLOAD, byte index = 0.
  - PAYLOAD: byte index increments on each accept. On accept of the last payload byte (index 7 or 39) → CSUM.
  - CSUM: on accept → IDLE; `frame_count` increments.
- The running checksum accumulates each byte at its accept, TYPE and payload bytes only.
- `busy` = 1 in every state except IDLE.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=8'h00, `busy`=0, `overrun`=0, `frame_count`=0, FSM=IDLE, `sol_prev`=0.
- Reset asserted mid-frame: the frame is abandoned immediately, with no partial completion and no count increment.
- Latency: trigger sampled at edge N → `tx_valid`=1 with `tx_data`=`SYNC_BYTE` after edge N (cycle N+1).
- Handshake:
  - A byte transfers on an edge where `tx_valid` and `tx_ready` are both 1.
  - `tx_valid` never drops and `tx_data` never changes until accepted.
  - `tx_ready` is ignored while `tx_valid`=0.
  - With `tx_ready` tied 1, a short frame occupies 11 consecutive cycles.
- After the CSUM accept, `tx_valid`=0 and `busy`=0 for at least one cycle.
  - A trigger sampled on the CSUM-accept edge is an overrun (FSM not yet IDLE).
  - A trigger on the following edge is captured.
- `frame_count` updates on the same edge as the CSUM accept.
- Back-to-back frames: `sol_valid` must go low for ≥1 sampled cycle, then high again.

## Test plan
- Short frame, SEND_RESULT=0, `tx_ready`=1:
  - Stimulus: time=32'h5F5E1000, nonce=32'h00000083, `sol_valid` rises.
  - Response: bytes A5 01 5F 5E 10 00 00 00 00 83 AF on 11 consecutive cycles starting one cycle after the trigger; then `frame_count`=1 and `busy`=0.
- Long frame, SEND_RESULT=1:
  - Stimulus: result=256'h0000…00FF (all zero except LSB byte), time=0, nonce=1.
  - Response: 43 bytes, TYPE=02, hash bytes 00×31 then FF, CSUM = −(02+01+FF) mod 256 = 8'hFE.
- Backpressure:
  - Stimulus: `tx_ready` toggles randomly 1-in-3 during a short frame.
  - Response: `tx_data` stable while `tx_valid`&~`tx_ready`; byte sequence identical to test 1; no byte duplicated or dropped.
- Overrun and snapshot:
  - Stimulus: during frame 1, drop `sol_valid` then re-raise it with new time/nonce.
  - Response: `overrun`=1; frame 1 still carries the original values; no second frame starts; `frame_count`=1.
- Held level:
  - Stimulus: `sol_valid` held high for 100 cycles.
  - Response: exactly one frame is sent.
  - Stimulus: `sol_valid` low 1 cycle, then high.
  - Response: a second frame is sent; `frame_count`=2.
- Reset mid-frame:
  - Stimulus: assert `RST` low after byte 5 is accepted.
  - Response: `tx_valid`=0, `busy`=0, `overrun`=0, `frame_count`=0 asynchronously.
  - Stimulus: release `RST` with `sol_valid` still high.
  - Response: a fresh frame starts from `SYNC_BYTE` one cycle after the first post-reset edge.

Source files
------------

// File: rtl/sha_result_tx.sv
// Serialises each newly found hasher solution into a checksummed byte frame
// and offers it over a valid/ready byte interface toward the host transport.
module sha_result_tx #(
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter bit         SEND_RESULT = 1'b1
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         sol_valid,
   input  logic [31:0]  sol_time,
   input  logic [31:0]  sol_nonce,
   input  logic [255:0] sol_result,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic         busy,
   output logic         overrun,
   output logic [15:0]  frame_count
);

   localparam logic [7:0] TYPE_BYTE = SEND_RESULT ? 8'h02 : 8'h01;
   localparam logic [5:0] LAST_IDX  = SEND_RESULT ? 6'd39 : 6'd7;

   typedef enum logic [2:0] {StIdle, StSync, StType, StPayload, StCsum} state_e;

   state_e         state_q;
   logic           sol_prev_q;
   logic [319:0]   snap_q;
   logic [5:0]     idx_q;
   logic [7:0]     sum_q;
   logic           trigger;
   logic           accept;
   logic [7:0]     sum_next;

   assign trigger  = sol_valid & ~sol_prev_q;
   assign accept   = tx_valid & tx_ready;
   assign sum_next = sum_q + tx_data;

   // The snapshot shifts left one byte per payload accept, so the next
   // payload byte is always at the top.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= StIdle;
         sol_prev_q  <= 1'b0;
         snap_q      <= '0;
         idx_q       <= '0;
         sum_q       <= '0;
         tx_data     <= 8'h00;
         tx_valid    <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
         frame_count <= 16'h0000;
      end else begin
         sol_prev_q <= sol_valid;
         if (trigger && state_q != StIdle) begin
            overrun <= 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               if (trigger) begin
                  snap_q   <= {sol_time, sol_nonce, sol_result};
                  state_q  <= StSync;
                  tx_data  <= SYNC_BYTE;
                  tx_valid <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            StSync: begin
               if (accept) begin
                  state_q <= StType;
                  tx_data <= TYPE_BYTE;
               end
            end
            StType: begin
               if (accept) begin
                  state_q <= StPayload;
                  idx_q   <= '0;
                  sum_q   <= TYPE_BYTE;
                  tx_data <= snap_q[319:312];
                  snap_q  <= {snap_q[311:0], 8'h00};
               end
            end
            StPayload: begin
               if (accept) begin
                  sum_q <= sum_next;
                  if (idx_q == LAST_IDX) begin
                     state_q <= StCsum;
                     tx_data <= 8'h00 - sum_next;
                  end else begin
                     idx_q   <= idx_q + 6'd1;
                     tx_data <= snap_q[319:312];
                     snap_q  <= {snap_q[311:0], 8'h00};
                  end
               end
            end
            StCsum: begin
               if (accept) begin
                  state_q     <= StIdle;
                  tx_valid    <= 1'b0;
                  busy        <= 1'b0;
                  frame_count <= frame_count + 16'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
